multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
//  Moore-style control FSM for the multicycle MIPS datapath. Sequences one shared memory and one shared ALU.
//  Supports R-type, lw, sw, beq, j and addi in 3-5 states each; ALUOp feeds the existing ALUControl unit.
//  Stalls on a memory-ready handshake; counts retired instructions.
// PARAMETERS
//  CNT_W  32  width of retired-instruction counter (wraps)
// PORTS
//  clk          in   1      system clock, rising edge
//  reset        in   1      synchronous, active-high
//  opcode       in   6      IR[31:26] from datapath IR; valid from DECODE onward
//  mem_ready    in   1      memory completes current read/write this cycle
//  PCWrite      out  1      unconditional PC load
//  PCWriteCond  out  1      PC load if ALU Zero (beq)
//  IorD         out  1      0=PC addresses memory, 1=ALUOut
//  MemRead      out  1      memory read request
//  MemWrite     out  1      memory write request
//  MemtoReg     out  1      1=MDR to register file, 0=ALUOut
//  IRWrite      out  1      load IR from memory data
//  PCSource     out  2      00=ALU, 01=ALUOut, 10=jump target
//  ALUOp        out  2      00=add, 01=sub, 10=funct field
//  ALUSrcA      out  1      0=PC, 1=reg A
//  ALUSrcB      out  2      00=reg B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
//  RegWrite     out  1      register file write
//  RegDst       out  1      1=rd, 0=rt
//  state        out  4      current state encoding (debug)
//  instr_done   out  1      1-cycle pulse in last state of each instruction
//  illegal_op   out  1      high in DECODE when opcode unsupported
//  instr_count  out  CNT_W  retired instructions
// BEHAVIOUR
//  Reset: state<=FETCH(0), instr_count<=0; while reset=1 all outputs forced 0.
//  Outputs are decoded from state only, except PCWrite/IRWrite in FETCH (gated by mem_ready).
//  Any output not listed for a state is 0.
//  States and transitions:
//   0 FETCH:   MemRead,IorD=0,ALUSrcA=0,ALUSrcB=01,ALUOp=00,PCSource=00; IRWrite=PCWrite=mem_ready;
//              mem_ready ? ->DECODE : stay.
//   1 DECODE:  ALUSrcA=0,ALUSrcB=11,ALUOp=00. opcode 000000->EXEC; 100011/101011->MEMADR;
//              000100->BRANCH; 000010->JUMP; 001000->ADDIEX; else illegal_op=1, ->FETCH.
//   2 MEMADR:  ALUSrcA=1,ALUSrcB=10,ALUOp=00; lw->MEMRD, sw->MEMWR.
//   3 MEMRD:   MemRead,IorD=1; mem_ready ? ->MEMWB : stay.
//   4 MEMWB:   RegWrite,MemtoReg=1,RegDst=0; ->FETCH.
//   5 MEMWR:   MemWrite,IorD=1; mem_ready ? ->FETCH : stay.
//   6 EXEC:    ALUSrcA=1,ALUSrcB=00,ALUOp=10; ->RTYPEWB.
//   7 RTYPEWB: RegWrite,RegDst=1,MemtoReg=0; ->FETCH.
//   8 BRANCH:  ALUSrcA=1,ALUSrcB=00,ALUOp=01,PCWriteCond,PCSource=01; ->FETCH.
//   9 JUMP:    PCWrite,PCSource=10; ->FETCH.
//   10 ADDIEX: ALUSrcA=1,ALUSrcB=10,ALUOp=00; ->ADDIWB.
//   11 ADDIWB: RegWrite,RegDst=0,MemtoReg=0; ->FETCH.
//   12-15:     unreachable; all outputs 0, ->FETCH next cycle.
//  Latency with mem_ready=1 every cycle:
//   lw=5, sw=4, R-type=4, addi=4, beq=3, j=3 cycles.
//   Each cycle mem_ready=0 in FETCH/MEMRD/MEMWR adds one cycle.
//  Stall: while waiting, request and address select held stable; no write enables pulse.
//   MemWrite is held until accepted.
//  instr_done=1 in MEMWB, RTYPEWB, ADDIWB, BRANCH, JUMP, and in MEMWR when mem_ready=1.
//   The same cycle's edge increments instr_count (wraps 2^CNT_W-1 -> 0).
//  Illegal opcode: not counted. instr_done=0; illegal_op high exactly one cycle.
//  Reset mid-instruction (any state, incl. stalled): next edge ->FETCH, count cleared.
//   No write enable is asserted in the reset cycle.
// TESTING
//  1 reset=1 two cycles, release, mem_ready=1 -> state 0, outputs per FETCH, instr_count=0.
//  2 opcode=000000, mem_ready=1 -> states 0,1,6,7,0.
//    RegWrite=1,RegDst=1 only in state 7; instr_count 0->1.
//  3 opcode=100011, mem_ready low 2 cycles in MEMRD -> 0,1,2,3,3,3,4,0.
//    MemRead/IorD=1 held in 3; RegWrite,MemtoReg=1 in 4; total 7 cycles.
//  4 opcode=101011 then 000100 then 000010 -> 0,1,2,5,0 / 0,1,8,0 / 0,1,9,0.
//    PCWriteCond=1 and ALUOp=01 in 8; PCSource=10 in 9; instr_count=3.
//  5 opcode=111111 -> illegal_op=1 in DECODE, back to FETCH, instr_count unchanged.
//    Then 001000 -> 0,1,10,11,0.
//  6 reset asserted while stalled in MEMWR (MemWrite=1) -> MemWrite=0 in reset cycle.
//    state=0 after edge, instr_count=0.

Source files
------------

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath: sequences the shared memory and ALU,
// stalls on the memory-ready handshake and counts retired instructions.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             IRWrite,
    output logic [1:0]       PCSource,
    output logic [1:0]       ALUOp,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             RegWrite,
    output logic             RegDst,
    output logic [3:0]       state,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_MEMADR  = 4'd2,
        ST_MEMRD   = 4'd3,
        ST_MEMWB   = 4'd4,
        ST_MEMWR   = 4'd5,
        ST_EXEC    = 4'd6,
        ST_RTYPEWB = 4'd7,
        ST_BRANCH  = 4'd8,
        ST_JUMP    = 4'd9,
        ST_ADDIEX  = 4'd10,
        ST_ADDIWB  = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_instr_count;

    logic       w_pc_write;
    logic       w_pc_write_cond;
    logic       w_iord;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_mem_to_reg;
    logic       w_ir_write;
    logic [1:0] w_pc_source;
    logic [1:0] w_alu_op;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic       w_reg_write;
    logic       w_reg_dst;
    logic       w_instr_done;
    logic       w_illegal_op;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Retired-instruction counter, wraps at 2^CNT_W
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr_count <= {CNT_W{1'b0}};
        end else if (w_instr_done) begin
            r_instr_count <= r_instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_instr_count <= r_instr_count;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = ST_FETCH;
        w_illegal_op = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (mem_ready) begin
                    w_next_state = ST_DECODE;
                end else begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE:     w_next_state = ST_EXEC;
                    OP_LW, OP_SW: w_next_state = ST_MEMADR;
                    OP_BEQ:       w_next_state = ST_BRANCH;
                    OP_J:         w_next_state = ST_JUMP;
                    OP_ADDI:      w_next_state = ST_ADDIEX;
                    default: begin
                        w_next_state = ST_FETCH;
                        w_illegal_op = 1'b1;
                    end
                endcase
            end
            ST_MEMADR: begin
                if (opcode == OP_SW) begin
                    w_next_state = ST_MEMWR;
                end else begin
                    w_next_state = ST_MEMRD;
                end
            end
            ST_MEMRD: begin
                if (mem_ready) begin
                    w_next_state = ST_MEMWB;
                end else begin
                    w_next_state = ST_MEMRD;
                end
            end
            ST_MEMWR: begin
                if (mem_ready) begin
                    w_next_state = ST_FETCH;
                end else begin
                    w_next_state = ST_MEMWR;
                end
            end
            ST_EXEC:   w_next_state = ST_RTYPEWB;
            ST_ADDIEX: w_next_state = ST_ADDIWB;
            default:   w_next_state = ST_FETCH;
        endcase
    end

    // Control decode: depends on state only, apart from the FETCH handshake terms
    always_comb begin
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_iord          = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_ir_write      = 1'b0;
        w_pc_source     = 2'b00;
        w_alu_op        = 2'b00;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = 2'b00;
        w_reg_write     = 1'b0;
        w_reg_dst       = 1'b0;
        w_instr_done    = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                w_ir_write  = mem_ready;
                w_pc_write  = mem_ready;
            end
            ST_DECODE: begin
                w_alu_src_b = 2'b11;
            end
            ST_MEMADR, ST_ADDIEX: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
            end
            ST_MEMRD: begin
                w_mem_read = 1'b1;
                w_iord     = 1'b1;
            end
            ST_MEMWB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_instr_done = 1'b1;
            end
            ST_MEMWR: begin
                w_mem_write  = 1'b1;
                w_iord       = 1'b1;
                w_instr_done = mem_ready;
            end
            ST_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b10;
            end
            ST_RTYPEWB: begin
                w_reg_write  = 1'b1;
                w_reg_dst    = 1'b1;
                w_instr_done = 1'b1;
            end
            ST_BRANCH: begin
                w_alu_src_a     = 1'b1;
                w_alu_op        = 2'b01;
                w_pc_write_cond = 1'b1;
                w_pc_source     = 2'b01;
                w_instr_done    = 1'b1;
            end
            ST_JUMP: begin
                w_pc_write   = 1'b1;
                w_pc_source  = 2'b10;
                w_instr_done = 1'b1;
            end
            ST_ADDIWB: begin
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
            end
            default: begin
                w_instr_done = 1'b0;
            end
        endcase
    end

    // Reset forces every output low so no write enable can fire in the reset cycle
    assign PCWrite     = w_pc_write      & ~reset;
    assign PCWriteCond = w_pc_write_cond & ~reset;
    assign IorD        = w_iord          & ~reset;
    assign MemRead     = w_mem_read      & ~reset;
    assign MemWrite    = w_mem_write     & ~reset;
    assign MemtoReg    = w_mem_to_reg    & ~reset;
    assign IRWrite     = w_ir_write      & ~reset;
    assign PCSource    = reset ? 2'b00 : w_pc_source;
    assign ALUOp       = reset ? 2'b00 : w_alu_op;
    assign ALUSrcA     = w_alu_src_a     & ~reset;
    assign ALUSrcB     = reset ? 2'b00 : w_alu_src_b;
    assign RegWrite    = w_reg_write     & ~reset;
    assign RegDst      = w_reg_dst       & ~reset;
    assign state       = reset ? 4'd0 : r_state;
    assign instr_done  = w_instr_done    & ~reset;
    assign illegal_op  = w_illegal_op    & ~reset;
    assign instr_count = reset ? {CNT_W{1'b0}} : r_instr_count;

endmodule
